fact_mmio_ctrl: RTL and testbench

//  Parametrised memory-mapped control/decoder for NCH factorial units. Decodes a word

---
 rtl/fact_mmio_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fact_mmio_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fact_mmio_ctrl.sv
// fact_mmio_ctrl: memory-mapped control/decoder for NCH factorial channels.
// Word address a = {channel, offset}; offsets 0=N, 1=CTRL, 2=STATUS, 3=RESULT.
// Reads are registered (rd/rd_valid one cycle after re).
// Optional build macro FACT_IRQ_EN adds per-channel interrupt enables and irq.
module fact_mmio_ctrl #(
    parameter int NCH = 2,
    parameter int DW  = 32,
    parameter int NW  = 4,
    localparam int AW = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     a,
    input  logic              we,
    input  logic [DW-1:0]     wd,
    input  logic              re,
    output logic [DW-1:0]     rd,
    output logic              rd_valid,
    output logic [NCH*NW-1:0] n_out,
    output logic [NCH-1:0]    go,
    output logic [NCH-1:0]    busy,
    input  logic [NCH-1:0]    done_in,
    input  logic [NCH-1:0]    err_in,
    input  logic [NCH*DW-1:0] result_in,
    output logic              irq
);

    localparam logic [1:0] OFF_N      = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RESULT = 2'd3;

    logic [NW-1:0]  nreg   [NCH];
    logic [DW-1:0]  resreg [NCH];
    logic [NCH-1:0] done;
    logic [NCH-1:0] err;
    logic [NCH-1:0] ovr;
`ifdef FACT_IRQ_EN
    logic [NCH-1:0] ie;
`endif

    logic [AW-1:0]  chw;
    logic [1:0]     off;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] ctrl_wr;
    logic [NCH-1:0] n_load;
    logic [NCH-1:0] go_start;
    logic [NCH-1:0] ovr_set;
    logic [NCH-1:0] fin;
    logic [NCH-1:0] res_rd;
    logic [NCH-1:0] stat_rd;
    logic [DW-1:0]  rd_next;
    logic           unused_wd;

    assign chw       = a >> 2;
    assign off       = a[1:0];
    assign unused_wd = ^wd[DW-1:NW];

    for (genvar k = 0; k < NCH; k++) begin : g_nout
        assign n_out[k*NW +: NW] = nreg[k];
    end

    // Decode the access into per-channel events and build the read-back word;
    // channel numbers >= NCH match no hit bit, so they read 0 and write nothing.
    always_comb begin
        logic [4:0] stat;
        hit      = '0;
        ctrl_wr  = '0;
        n_load   = '0;
        go_start = '0;
        ovr_set  = '0;
        fin      = '0;
        res_rd   = '0;
        stat_rd  = '0;
        rd_next  = '0;
        stat     = '0;
        for (int k = 0; k < NCH; k++) begin
            hit[k]      = (chw == AW'(k));
            ctrl_wr[k]  = we && hit[k] && (off == OFF_CTRL);
            n_load[k]   = we && hit[k] && (off == OFF_N) && !busy[k];
            go_start[k] = ctrl_wr[k] && wd[0] && !busy[k];
            ovr_set[k]  = busy[k] && we && hit[k] &&
                          ((off == OFF_N) || ((off == OFF_CTRL) && wd[0]));
            fin[k]      = done_in[k] && busy[k];
            res_rd[k]   = re && hit[k] && (off == OFF_RESULT);
            stat_rd[k]  = re && hit[k] && (off == OFF_STATUS);
            if (hit[k]) begin
`ifdef FACT_IRQ_EN
                stat = {ie[k], ovr[k], err[k], done[k], busy[k]};
`else
                stat = {1'b0, ovr[k], err[k], done[k], busy[k]};
`endif
                case (off)
                    OFF_N:      rd_next = DW'(nreg[k]);
                    OFF_STATUS: rd_next = DW'(stat);
                    OFF_RESULT: rd_next = resreg[k];
                    default:    rd_next = '0;
                endcase
            end
        end
    end

    // Register file, busy/done tracking and read-back; set events win over read clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            go       <= '0;
            busy     <= '0;
            done     <= '0;
            err      <= '0;
            ovr      <= '0;
            rd       <= '0;
            rd_valid <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                nreg[k]   <= '0;
                resreg[k] <= '0;
            end
        end else begin
            go       <= '0;
            rd_valid <= re;
            if (re) begin
                rd <= rd_next;
            end
            for (int k = 0; k < NCH; k++) begin
                if (n_load[k]) begin
                    nreg[k] <= wd[NW-1:0];
                end
                if (go_start[k]) begin
                    go[k]   <= 1'b1;
                    busy[k] <= 1'b1;
                    done[k] <= 1'b0;
                    err[k]  <= 1'b0;
                end else if (fin[k]) begin
                    resreg[k] <= result_in[k*DW +: DW];
                    err[k]    <= err_in[k];
                    done[k]   <= 1'b1;
                    busy[k]   <= 1'b0;
                end else if (res_rd[k]) begin
                    done[k] <= 1'b0;
                end
                if (ovr_set[k]) begin
                    ovr[k] <= 1'b1;
                end else if (stat_rd[k]) begin
                    ovr[k] <= 1'b0;
                end
            end
        end
    end

`ifdef FACT_IRQ_EN
    // Interrupt enables latch on every CTRL write; irq follows done&ie one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (ctrl_wr[k]) begin
                    ie[k] <= wd[1];
                end
            end
            irq <= |(done & ie);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fact_mmio_ctrl.sv
// tb_fact_mmio_ctrl: directed bench for fact_mmio_ctrl with a read-data scoreboard.
// Built with NCH=3 so that channel number 3 is an unmapped address.
module tb_fact_mmio_ctrl;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int NW  = 4;
    localparam int AW  = 4;
`ifdef FACT_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     a;
    logic              we;
    logic [DW-1:0]     wd;
    logic              re;
    logic [DW-1:0]     rd;
    logic              rd_valid;
    logic [NCH*NW-1:0] n_out;
    logic [NCH-1:0]    go;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done_in;
    logic [NCH-1:0]    err_in;
    logic [NCH*DW-1:0] result_in;
    logic              irq;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] expq[$];

    fact_mmio_ctrl #(.NCH(NCH), .DW(DW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd), .re(re),
        .rd(rd), .rd_valid(rd_valid), .n_out(n_out), .go(go), .busy(busy),
        .done_in(done_in), .err_in(err_in), .result_in(result_in), .irq(irq)
    );

    always #5 clk = ~clk;

    // One comparison: counted, and reported with tag, observed and expected on failure.
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; a read queues its expected data for the monitor.
    task automatic applyStimulus(input logic w, input logic r, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] exp);
        we = w;
        re = r;
        a  = addr;
        wd = data;
        if (r) expq.push_back(exp);
        tick();
        we      = 1'b0;
        re      = 1'b0;
        done_in = '0;
        err_in  = '0;
    endtask

    // Present a completion from core ch during the next bus cycle.
    task automatic setDone(input int ch, input logic e, input logic [DW-1:0] val);
        result_in              = '0;
        result_in[ch*DW +: DW] = val;
        done_in[ch]            = 1'b1;
        err_in[ch]             = e;
    endtask

    // Scoreboard monitor: every rd_valid cycle must match the oldest pending read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checkOutput("rd_valid_has_pending_read", DW'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) checkOutput("rd_data", rd, expq.pop_front());
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; a = '0; wd = '0;
        done_in = '0; err_in = '0; result_in = '0;
        tick();
        tick();
        checkOutput("reset_rd", rd, 32'd0);
        checkOutput("reset_rd_valid", DW'(rd_valid), 32'd0);
        checkOutput("reset_go", DW'(go), 32'd0);
        checkOutput("reset_busy", DW'(busy), 32'd0);
        checkOutput("reset_irq", DW'(irq), 32'd0);
        checkOutput("reset_n_out", DW'(n_out), 32'd0);
        rst = 1'b0;

        $display("[TB] start ch0 with N=5");
        applyStimulus(1, 0, 4'd0, 32'd5, 0);
        checkOutput("n_out_ch0", DW'(n_out[3:0]), 32'd5);
        applyStimulus(1, 0, 4'd1, 32'd1, 0);
        checkOutput("go_pulse_ch0", DW'(go), 32'b001);
        checkOutput("busy_after_go", DW'(busy), 32'b001);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("go_one_cycle", DW'(go), 32'd0);

        $display("[TB] ch0 completes with 120");
        setDone(0, 1'b0, 32'd120);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("busy_after_done", DW'(busy), 32'd0);
        applyStimulus(0, 1, 4'd2, 0, 32'h2);
        applyStimulus(0, 1, 4'd3, 0, 32'd120);
        applyStimulus(0, 1, 4'd2, 0, 32'h0);

        $display("[TB] ch1 overrun while busy");
        applyStimulus(1, 0, 4'd4, 32'd7, 0);
        applyStimulus(1, 0, 4'd5, 32'd1, 0);
        checkOutput("busy_ch1", DW'(busy), 32'b010);
        applyStimulus(1, 0, 4'd4, 32'd3, 0);
        applyStimulus(1, 0, 4'd5, 32'd1, 0);
        checkOutput("no_go_when_busy", DW'(go), 32'd0);
        checkOutput("n_unchanged_when_busy", DW'(n_out), 32'h075);
        applyStimulus(0, 1, 4'd6, 0, 32'h9);
        applyStimulus(0, 1, 4'd6, 0, 32'h1);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("rd_holds", rd, 32'h1);
        checkOutput("rd_valid_one_cycle", DW'(rd_valid), 32'd0);

        $display("[TB] unmapped channel");
        applyStimulus(0, 1, 4'd14, 0, 32'd0);
        applyStimulus(0, 1, 4'd15, 0, 32'd0);
        applyStimulus(1, 0, 4'd12, 32'd9, 0);
        applyStimulus(1, 0, 4'd13, 32'd1, 0);
        checkOutput("unmapped_no_go", DW'(go), 32'd0);
        checkOutput("unmapped_n_out", DW'(n_out), 32'h075);
        checkOutput("unmapped_busy", DW'(busy), 32'b010);

        $display("[TB] done_in racing a RESULT read");
        applyStimulus(1, 0, 4'd1, 32'd1, 0);
        applyStimulus(0, 1, 4'd2, 0, 32'h1);
        setDone(0, 1'b1, 32'd720);
        applyStimulus(0, 1, 4'd3, 0, 32'd120);
        applyStimulus(0, 1, 4'd2, 0, 32'h6);
        applyStimulus(0, 1, 4'd3, 0, 32'd720);
        applyStimulus(0, 1, 4'd2, 0, 32'h4);
        applyStimulus(1, 0, 4'd1, 32'd1, 0);
        applyStimulus(0, 1, 4'd2, 0, 32'h1);
        setDone(0, 1'b0, 32'd24);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("busy_ch0_done_again", DW'(busy), 32'b010);
        applyStimulus(1, 1, 4'd0, 32'd6, 32'd5);
        applyStimulus(0, 1, 4'd0, 0, 32'd6);
        checkOutput("n_out_after_rw", DW'(n_out), 32'h076);

        $display("[TB] GO racing done_in on ch1");
        setDone(1, 1'b0, 32'd6);
        applyStimulus(1, 0, 4'd5, 32'd1, 0);
        checkOutput("no_go_on_race", DW'(go), 32'd0);
        checkOutput("busy_clear_on_race", DW'(busy), 32'd0);
        applyStimulus(0, 1, 4'd6, 0, 32'hA);
        applyStimulus(0, 1, 4'd6, 0, 32'h2);
        applyStimulus(0, 1, 4'd7, 0, 32'd6);

        $display("[TB] interrupt path on ch1");
        applyStimulus(1, 0, 4'd5, 32'd3, 0);
        checkOutput("go_ch1_ie", DW'(go), 32'b010);
        setDone(1, 1'b0, 32'd24);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("irq_not_yet", DW'(irq), 32'd0);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("irq_raised", DW'(irq), DW'(IRQ));
        applyStimulus(0, 1, 4'd6, 0, IRQ ? 32'h12 : 32'h02);
        applyStimulus(0, 1, 4'd7, 0, 32'd24);
        checkOutput("irq_still_up", DW'(irq), DW'(IRQ));
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("irq_cleared", DW'(irq), 32'd0);

        $display("[TB] reset while busy");
        applyStimulus(1, 0, 4'd1, 32'd1, 0);
        checkOutput("busy_before_rst", DW'(busy), 32'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("busy_after_rst", DW'(busy), 32'd0);
        checkOutput("n_out_after_rst", DW'(n_out), 32'd0);
        setDone(0, 1'b0, 32'd999);
        applyStimulus(0, 0, 4'd0, 0, 0);
        checkOutput("late_done_ignored", DW'(busy), 32'd0);
        applyStimulus(0, 1, 4'd2, 0, 32'h0);

        repeat (3) tick();
        checkOutput("scoreboard_drained", DW'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
